// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, field positions, and the
// control-word decoder used by decode.
package decode_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int OP_W   = 5;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 11;
    localparam int RS_MSB = 10;
    localparam int RS_LSB = 8;
    localparam int RT_MSB = 7;
    localparam int RT_LSB = 5;
    localparam int RD_MSB = 4;
    localparam int RD_LSB = 2;

    localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ILL0 = 5'b00010;
    localparam logic [OP_W-1:0] OP_ILL1 = 5'b00011;
    localparam logic [OP_W-1:0] OP_J    = 5'b00100;
    localparam logic [OP_W-1:0] OP_JR   = 5'b00101;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_JALR = 5'b00111;
    localparam logic [OP_W-1:0] OP_ST   = 5'b10000;
    localparam logic [OP_W-1:0] OP_LD   = 5'b10001;
    localparam logic [OP_W-1:0] OP_SLBI = 5'b10010;
    localparam logic [OP_W-1:0] OP_STU  = 5'b10011;
    localparam logic [OP_W-1:0] OP_LBI  = 5'b11000;
    localparam logic [OP_W-1:0] OP_BTR  = 5'b11001;

    typedef enum logic [1:0] {IMM_NONE, IMM_5, IMM_8, IMM_11} imm_fmt_e;

    typedef struct packed {
        logic             has_dest;
        logic [REG_W-1:0] dest;
        logic             uses_rs;
        logic             uses_rt;
        imm_fmt_e         imm_fmt;
        logic             imm_zext;
        logic             mem_read;
        logic             mem_write;
        logic             illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [DATA_W-1:0] instr);
        ctrl_t            c;
        logic [OP_W-1:0]  op;
        op        = instr[OP_MSB:OP_LSB];
        c         = '0;
        c.imm_fmt = IMM_NONE;
        c.uses_rs = 1'b1;
        casez (op)
            OP_HALT, OP_NOP: c.uses_rs = 1'b0;
            OP_ILL0, OP_ILL1: c.illegal = 1'b1;
            OP_J: begin
                c.uses_rs = 1'b0;
                c.imm_fmt = IMM_11;
            end
            OP_JAL: begin
                c.uses_rs  = 1'b0;
                c.imm_fmt  = IMM_11;
                c.has_dest = 1'b1;
                c.dest     = 3'd7;
            end
            OP_JR: c.imm_fmt = IMM_8;
            OP_JALR: begin
                c.imm_fmt  = IMM_8;
                c.has_dest = 1'b1;
                c.dest     = 3'd7;
            end
            5'b010??, 5'b101??: begin
                // Logical immediates (XORI/ANDNI, ROLI/SLLI) are zero-extended.
                c.imm_fmt  = IMM_5;
                c.imm_zext = (op[4:1] == 4'b0101) || (op[4:1] == 4'b1010);
                c.has_dest = 1'b1;
                c.dest     = instr[RT_MSB:RT_LSB];
            end
            5'b011??: c.imm_fmt = IMM_8;
            OP_ST: begin
                c.imm_fmt   = IMM_5;
                c.uses_rt   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_LD: begin
                c.imm_fmt  = IMM_5;
                c.mem_read = 1'b1;
                c.has_dest = 1'b1;
                c.dest     = instr[RT_MSB:RT_LSB];
            end
            OP_SLBI: begin
                c.imm_fmt  = IMM_8;
                c.imm_zext = 1'b1;
                c.has_dest = 1'b1;
                c.dest     = instr[RS_MSB:RS_LSB];
            end
            OP_STU: begin
                c.imm_fmt   = IMM_5;
                c.uses_rt   = 1'b1;
                c.mem_write = 1'b1;
                c.has_dest  = 1'b1;
                c.dest      = instr[RS_MSB:RS_LSB];
            end
            OP_LBI: begin
                c.uses_rs  = 1'b0;
                c.imm_fmt  = IMM_8;
                c.has_dest = 1'b1;
                c.dest     = instr[RS_MSB:RS_LSB];
            end
            OP_BTR: begin
                c.has_dest = 1'b1;
                c.dest     = instr[RD_MSB:RD_LSB];
            end
            5'b1101?, 5'b111??: begin
                c.uses_rt  = 1'b1;
                c.has_dest = 1'b1;
                c.dest     = instr[RD_MSB:RD_LSB];
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_regfile_bypass.sv
// 8x16 register file: two asynchronous read ports, one write port, and a
// write-to-read bypass so a same-cycle read sees the value being written.
module regfile_bypass
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_W-1:0]  i_raddr_a,
    input  logic [REG_W-1:0]  i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_mem[i_raddr_a];
    assign o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_mem[i_raddr_b];

endmodule

// File: rtl/decode.sv
// ID stage: register read, control decode, RAW hazard detection and the
// ID/EX pipeline register (bubbles on stall or taken-branch flush).
module decode
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr_IFID,
    input  logic [DATA_W-1:0] PC_IFID,
    input  logic [DATA_W-1:0] PC2_IFID,
    input  logic              halt_IFID,
    input  logic              takeBranch_EXMEM,
    input  logic              regWrite_EXMEM,
    input  logic [REG_W-1:0]  writeReg_EXMEM,
    input  logic              regWrite_WB,
    input  logic [REG_W-1:0]  writeReg_WB,
    input  logic [DATA_W-1:0] writeData_WB,
    output logic [DATA_W-1:0] instr_IDEX,
    output logic [DATA_W-1:0] PC_IDEX,
    output logic [DATA_W-1:0] PC2_IDEX,
    output logic [DATA_W-1:0] rsData_IDEX,
    output logic [DATA_W-1:0] rtData_IDEX,
    output logic [DATA_W-1:0] imm_IDEX,
    output logic [REG_W-1:0]  writeReg_IDEX,
    output logic              regWrite_IDEX,
    output logic              memRead_IDEX,
    output logic              memWrite_IDEX,
    output logic              halt_IDEX,
    output logic              stallCtrl,
    output logic              startStall,
    output logic              err
);

    ctrl_t             w_ctrl;
    logic [REG_W-1:0]  w_rs;
    logic [REG_W-1:0]  w_rt;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_imm;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_bubble;
    logic              r_stall_q;

    assign w_ctrl = decode_ctrl(instr_IFID);
    assign w_rs   = instr_IFID[RS_MSB:RS_LSB];
    assign w_rt   = instr_IFID[RT_MSB:RT_LSB];

    regfile_bypass u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (regWrite_WB),
        .i_waddr   (writeReg_WB),
        .i_wdata   (writeData_WB),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data)
    );

    // No forwarding: any pending writer in EX or MEM of a used source stalls.
    assign w_rs_hit = w_ctrl.uses_rs &&
                      ((regWrite_IDEX && (w_rs == writeReg_IDEX)) ||
                       (regWrite_EXMEM && (w_rs == writeReg_EXMEM)));
    assign w_rt_hit = w_ctrl.uses_rt &&
                      ((regWrite_IDEX && (w_rt == writeReg_IDEX)) ||
                       (regWrite_EXMEM && (w_rt == writeReg_EXMEM)));

    assign stallCtrl  = (w_rs_hit | w_rt_hit) & ~takeBranch_EXMEM;
    assign startStall = stallCtrl & ~r_stall_q;
    assign w_bubble   = takeBranch_EXMEM | stallCtrl;

    always_comb begin
        w_imm = '0;
        unique case (w_ctrl.imm_fmt)
            IMM_5:   w_imm = w_ctrl.imm_zext ? {11'b0, instr_IFID[4:0]}
                                             : {{11{instr_IFID[4]}}, instr_IFID[4:0]};
            IMM_8:   w_imm = w_ctrl.imm_zext ? {8'b0, instr_IFID[7:0]}
                                             : {{8{instr_IFID[7]}}, instr_IFID[7:0]};
            IMM_11:  w_imm = {{5{instr_IFID[10]}}, instr_IFID[10:0]};
            default: w_imm = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_q <= 1'b0;
        end else begin
            r_stall_q <= stallCtrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_IDEX    <= NOP_INSTR;
            PC_IDEX       <= '0;
            PC2_IDEX      <= '0;
            rsData_IDEX   <= '0;
            rtData_IDEX   <= '0;
            imm_IDEX      <= '0;
            writeReg_IDEX <= '0;
            regWrite_IDEX <= 1'b0;
            memRead_IDEX  <= 1'b0;
            memWrite_IDEX <= 1'b0;
            halt_IDEX     <= 1'b0;
            err           <= 1'b0;
        end else if (w_bubble) begin
            instr_IDEX    <= NOP_INSTR;
            PC_IDEX       <= PC_IFID;
            PC2_IDEX      <= '0;
            rsData_IDEX   <= '0;
            rtData_IDEX   <= '0;
            imm_IDEX      <= '0;
            writeReg_IDEX <= '0;
            regWrite_IDEX <= 1'b0;
            memRead_IDEX  <= 1'b0;
            memWrite_IDEX <= 1'b0;
            halt_IDEX     <= 1'b0;
            err           <= 1'b0;
        end else begin
            instr_IDEX    <= instr_IFID;
            PC_IDEX       <= PC_IFID;
            PC2_IDEX      <= PC2_IFID;
            rsData_IDEX   <= w_rs_data;
            rtData_IDEX   <= w_rt_data;
            imm_IDEX      <= w_imm;
            writeReg_IDEX <= w_ctrl.dest;
            regWrite_IDEX <= w_ctrl.has_dest;
            memRead_IDEX  <= w_ctrl.mem_read;
            memWrite_IDEX <= w_ctrl.mem_write;
            halt_IDEX     <= halt_IFID;
            err           <= w_ctrl.illegal;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: an opcode-table model predicts ID/EX and the
// stall pair every cycle, plus literal expectations for the key scenarios.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_IFID, PC_IFID, PC2_IFID;
    logic        halt_IFID, takeBranch_EXMEM, regWrite_EXMEM, regWrite_WB;
    logic [2:0]  writeReg_EXMEM, writeReg_WB;
    logic [15:0] writeData_WB;
    logic [15:0] instr_IDEX, PC_IDEX, PC2_IDEX, rsData_IDEX, rtData_IDEX, imm_IDEX;
    logic [2:0]  writeReg_IDEX;
    logic        regWrite_IDEX, memRead_IDEX, memWrite_IDEX, halt_IDEX;
    logic        stallCtrl, startStall, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .rst(rst),
        .instr_IFID(instr_IFID), .PC_IFID(PC_IFID), .PC2_IFID(PC2_IFID),
        .halt_IFID(halt_IFID), .takeBranch_EXMEM(takeBranch_EXMEM),
        .regWrite_EXMEM(regWrite_EXMEM), .writeReg_EXMEM(writeReg_EXMEM),
        .regWrite_WB(regWrite_WB), .writeReg_WB(writeReg_WB), .writeData_WB(writeData_WB),
        .instr_IDEX(instr_IDEX), .PC_IDEX(PC_IDEX), .PC2_IDEX(PC2_IDEX),
        .rsData_IDEX(rsData_IDEX), .rtData_IDEX(rtData_IDEX), .imm_IDEX(imm_IDEX),
        .writeReg_IDEX(writeReg_IDEX), .regWrite_IDEX(regWrite_IDEX),
        .memRead_IDEX(memRead_IDEX), .memWrite_IDEX(memWrite_IDEX), .halt_IDEX(halt_IDEX),
        .stallCtrl(stallCtrl), .startStall(startStall), .err(err)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] instr, pc, pc2, rs, rt, imm;
        logic [2:0]  wr;
        logic        rw, mr, mw, halt, err;
    } idex_t;

    idex_t       m_q, m_d;
    logic [15:0] m_rf [8];
    logic        m_stall_q, m_valid, exp_stall, exp_start;

    // Destination register index, or -1 when the opcode writes nothing.
    function automatic int dest_of(input logic [15:0] ins);
        int op = int'(ins[15:11]);
        if (op inside {25, [26:27], [28:31]}) return int'(ins[4:2]);
        if (op inside {[8:11], [20:23], 17})  return int'(ins[7:5]);
        if (op inside {24, 18, 19})           return int'(ins[10:8]);
        if (op inside {6, 7})                 return 7;
        return -1;
    endfunction

    function automatic logic [15:0] imm_of(input logic [15:0] ins);
        int op = int'(ins[15:11]);
        if (op inside {4, 6})                 return 16'($signed(ins[10:0]));
        if (op == 18)                         return {8'h00, ins[7:0]};
        if (op inside {5, 7, [12:15], 24})    return 16'($signed(ins[7:0]));
        if (op inside {10, 11, 20, 21})       return {11'h000, ins[4:0]};
        if (op inside {8, 9, 22, 23, 16, 17, 19}) return 16'($signed(ins[4:0]));
        return 16'h0000;
    endfunction

    function automatic logic pending(input int r, input idex_t q, input logic rwm, input logic [2:0] wrm);
        return (q.rw && int'(q.wr) == r) || (rwm && int'(wrm) == r);
    endfunction

    always_comb begin
        int op, d;
        logic hz;
        op = int'(instr_IFID[15:11]);
        hz = 1'b0;
        if (!(op inside {0, 1, 4, 6, 24}) && pending(int'(instr_IFID[10:8]), m_q, regWrite_EXMEM, writeReg_EXMEM))
            hz = 1'b1;
        if ((op inside {[26:31], 16, 19}) && pending(int'(instr_IFID[7:5]), m_q, regWrite_EXMEM, writeReg_EXMEM))
            hz = 1'b1;
        exp_stall = hz && !takeBranch_EXMEM;
        exp_start = exp_stall && !m_stall_q;
        m_d       = '0;
        m_d.instr = 16'h0800;
        m_d.pc    = PC_IFID;
        d         = dest_of(instr_IFID);
        if (!takeBranch_EXMEM && !exp_stall) begin
            m_d.instr = instr_IFID;
            m_d.pc2   = PC2_IFID;
            m_d.rs    = (regWrite_WB && writeReg_WB == instr_IFID[10:8]) ? writeData_WB : m_rf[instr_IFID[10:8]];
            m_d.rt    = (regWrite_WB && writeReg_WB == instr_IFID[7:5])  ? writeData_WB : m_rf[instr_IFID[7:5]];
            m_d.imm   = imm_of(instr_IFID);
            m_d.rw    = (d >= 0);
            m_d.wr    = (d >= 0) ? 3'(d) : 3'd0;
            m_d.mr    = (op == 17);
            m_d.mw    = (op == 16 || op == 19);
            m_d.halt  = halt_IFID;
            m_d.err   = (op == 2 || op == 3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '{instr: 16'h0800, default: '0};
            m_stall_q <= 1'b0;
            m_valid   <= 1'b1;
            for (int i = 0; i < 8; i++) m_rf[i] <= 16'h0000;
        end else begin
            m_q       <= m_d;
            m_stall_q <= exp_stall;
            if (regWrite_WB) m_rf[writeReg_WB] <= writeData_WB;
        end
    end

    initial m_valid = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("instr_IDEX", instr_IDEX, m_q.instr);
            chk("PC_IDEX", PC_IDEX, m_q.pc);
            chk("PC2_IDEX", PC2_IDEX, m_q.pc2);
            chk("rsData_IDEX", rsData_IDEX, m_q.rs);
            chk("rtData_IDEX", rtData_IDEX, m_q.rt);
            chk("imm_IDEX", imm_IDEX, m_q.imm);
            chk("writeReg_IDEX", {13'd0, writeReg_IDEX}, {13'd0, m_q.wr});
            chk("regWrite_IDEX", {15'd0, regWrite_IDEX}, {15'd0, m_q.rw});
            chk("memRead_IDEX", {15'd0, memRead_IDEX}, {15'd0, m_q.mr});
            chk("memWrite_IDEX", {15'd0, memWrite_IDEX}, {15'd0, m_q.mw});
            chk("halt_IDEX", {15'd0, halt_IDEX}, {15'd0, m_q.halt});
            chk("err", {15'd0, err}, {15'd0, m_q.err});
            chk("stallCtrl", {15'd0, stallCtrl}, {15'd0, exp_stall});
            chk("startStall", {15'd0, startStall}, {15'd0, exp_start});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        PC_IFID  = PC_IFID + 16'd2;
        PC2_IFID = PC_IFID + 16'd2;
    endtask

    task automatic lit(input string nm, input logic act, input logic exp);
        chk(nm, {15'd0, act}, {15'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        instr_IFID = 16'h0800; PC_IFID = 16'h0100; PC2_IFID = 16'h0102;
        halt_IFID = 0; takeBranch_EXMEM = 0; regWrite_EXMEM = 0; writeReg_EXMEM = 0;
        regWrite_WB = 0; writeReg_WB = 0; writeData_WB = 0;
        repeat (3) step();
        rst = 1'b0;
        chk("lit_reset_instr", instr_IDEX, 16'h0800);
        lit("lit_reset_regWrite", regWrite_IDEX, 1'b0);
        lit("lit_reset_stall", stallCtrl, 1'b0);
        lit("lit_reset_err", err, 1'b0);

        instr_IFID = 16'hDDC4;                    // ADD R1,R5,R6
        step();
        chk("lit_rf_reset_rs", rsData_IDEX, 16'h0000);
        chk("lit_rf_reset_rt", rtData_IDEX, 16'h0000);

        instr_IFID = 16'hDB64;                    // ADD R1,R3,R3 with WB R3=BEEF
        regWrite_WB = 1; writeReg_WB = 3'd3; writeData_WB = 16'hBEEF;
        #1 lit("lit_bypass_nostall", stallCtrl, 1'b0);
        step();
        regWrite_WB = 0; instr_IFID = 16'h0800;
        chk("lit_bypass_rs", rsData_IDEX, 16'hBEEF);
        chk("lit_bypass_rt", rtData_IDEX, 16'hBEEF);

        step();
        instr_IFID = 16'h405F;                    // ADDI R2,R0,#-1
        step();
        chk("lit_addi_imm", imm_IDEX, 16'hFFFF);
        instr_IFID = 16'hDA4C;                    // ADD R3,R2,R2
        #1 lit("lit_stall1", stallCtrl, 1'b1);
        lit("lit_start1", startStall, 1'b1);
        step();
        chk("lit_bubble1", instr_IDEX, 16'h0800);
        regWrite_EXMEM = 1; writeReg_EXMEM = 3'd2;
        #1 lit("lit_stall2", stallCtrl, 1'b1);
        lit("lit_start2", startStall, 1'b0);
        step();
        chk("lit_bubble2", instr_IDEX, 16'h0800);
        regWrite_EXMEM = 0;
        regWrite_WB = 1; writeReg_WB = 3'd2; writeData_WB = 16'hFFFF;
        #1 lit("lit_stall_end", stallCtrl, 1'b0);
        step();
        regWrite_WB = 0; instr_IFID = 16'h0800;
        chk("lit_issue_instr", instr_IDEX, 16'hDA4C);
        chk("lit_issue_rs", rsData_IDEX, 16'hFFFF);

        step();
        instr_IFID = 16'h405F;
        step();
        instr_IFID = 16'hDA4C; takeBranch_EXMEM = 1;
        #1 lit("lit_flush_stall", stallCtrl, 1'b0);
        lit("lit_flush_start", startStall, 1'b0);
        step();
        takeBranch_EXMEM = 0; instr_IFID = 16'h0800;
        chk("lit_flush_bubble", instr_IDEX, 16'h0800);
        lit("lit_flush_regWrite", regWrite_IDEX, 1'b0);

        instr_IFID = 16'h0000; halt_IFID = 1;
        step();
        lit("lit_halt", halt_IDEX, 1'b1);
        takeBranch_EXMEM = 1;
        step();
        lit("lit_halt_flushed", halt_IDEX, 1'b0);
        takeBranch_EXMEM = 0; halt_IFID = 0; instr_IFID = 16'h1000;
        step();
        lit("lit_err", err, 1'b1);
        instr_IFID = 16'h94FF;                    // SLBI R4,#FF
        step();
        lit("lit_err_clear", err, 1'b0);
        chk("lit_slbi_imm", imm_IDEX, 16'h00FF);
        instr_IFID = 16'hC4FF;                    // LBI R4,#FF
        step();
        chk("lit_lbi_imm", imm_IDEX, 16'hFFFF);
        instr_IFID = 16'h0800;

        step();
        instr_IFID = 16'h405F;
        step();
        instr_IFID = 16'hDA4C;
        #1 lit("lit_prereset_start", startStall, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        regWrite_EXMEM = 1; writeReg_EXMEM = 3'd2;
        #1 chk("lit_midrst_bubble", instr_IDEX, 16'h0800);
        lit("lit_midrst_stall", stallCtrl, 1'b1);
        lit("lit_midrst_start", startStall, 1'b1);
        step();
        regWrite_EXMEM = 0;
        step();
        chk("lit_midrst_issue", instr_IDEX, 16'hDA4C);
        instr_IFID = 16'h0800;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
